// File: rtl/conv_ctrl_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Package     : conv_ctrl_pkg
// Description : Shared state encoding and default widths for conv_scheduler.
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
package conv_ctrl_pkg;

  localparam int FSIZE_W_DEF = 4;
  localparam int NFILT_W_DEF = 3;
  localparam int NROW_W_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    CFG   = 3'd2,
    RUN   = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/limit_counter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module      : limit_counter
// Description : Up-counter that wraps to zero after reaching limit-1 and
//               flags when it sits on that final value.
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
module limit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_inc,
  input  logic [W-1:0] i_limit,
  output logic         o_last
);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == (i_limit - W'(1)));
  assign o_last = w_last;

  // Count accepted increments; wrap on the last value so the count never exceeds the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= w_last ? '0 : (r_cnt + W'(1));
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module      : conv_scheduler
// Description : Main controller of the convolution engine. Sequences data and
//               filter reads per window, stores each sum with output-buffer
//               back-pressure, walks filters and rows, pulses done at the end.
//               Optional feature macro: CONV_STALL_CNT_EN (adds stall_cycles).
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
module conv_scheduler
  import conv_ctrl_pkg::*;
#(
  parameter int FSIZE_W = FSIZE_W_DEF,
  parameter int NFILT_W = NFILT_W_DEF,
  parameter int NROW_W  = NROW_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FSIZE_W-1:0] cfg_filter_size,
  input  logic [NFILT_W-1:0] cfg_num_filters,
  input  logic [NROW_W-1:0]  cfg_num_rows,
  input  logic               av_data,
  input  logic               av_filter,
  input  logic               end_of_row,
  input  logic               out_full,
  output logic               ld_stride,
  output logic               ld_filter_size,
  output logic               put_data,
  output logic               put_filter,
  output logic               clear_sum,
  output logic               store_buffer,
  output logic               next_filter,
  output logic               next_row,
  output logic               busy,
  output logic               done
`ifdef CONV_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  state_t r_state;
  state_t w_next;

  logic [FSIZE_W-1:0] r_fsize;
  logic [NFILT_W-1:0] r_nfilt;
  logic [NROW_W-1:0]  r_nrow;

  logic w_in_cfg;
  logic w_fire;
  logic w_run_fire;
  logic w_store_go;
  logic w_elem_last;
  logic w_filt_last;
  logic w_row_last;
  logic w_filt_inc;
  logic w_row_inc;

  assign w_in_cfg   = (r_state == CFG);
  assign w_fire     = av_data & av_filter;
  assign w_run_fire = (r_state == RUN) & w_fire;
  assign w_store_go = (r_state == STORE) & ~out_full;
  assign w_filt_inc = w_store_go & end_of_row;
  assign w_row_inc  = w_filt_inc & w_filt_last & ~w_row_last;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the run configuration once in CFG; a zero field means one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsize <= '0;
      r_nfilt <= '0;
      r_nrow  <= '0;
    end else if (w_in_cfg) begin
      r_fsize <= (cfg_filter_size == '0) ? FSIZE_W'(1) : cfg_filter_size;
      r_nfilt <= (cfg_num_filters == '0) ? NFILT_W'(1) : cfg_num_filters;
      r_nrow  <= (cfg_num_rows    == '0) ? NROW_W'(1)  : cfg_num_rows;
    end
  end

  limit_counter #(.W(FSIZE_W)) u_elem_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_in_cfg),
    .i_inc   (w_run_fire),
    .i_limit (r_fsize),
    .o_last  (w_elem_last)
  );

  limit_counter #(.W(NFILT_W)) u_filt_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_in_cfg),
    .i_inc   (w_filt_inc),
    .i_limit (r_nfilt),
    .o_last  (w_filt_last)
  );

  limit_counter #(.W(NROW_W)) u_row_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_in_cfg),
    .i_inc   (w_row_inc),
    .i_limit (r_nrow),
    .o_last  (w_row_last)
  );

  // Next-state decode and Moore/Mealy control outputs.
  always_comb begin
    w_next         = r_state;
    ld_stride      = 1'b0;
    ld_filter_size = 1'b0;
    put_data       = 1'b0;
    put_filter     = 1'b0;
    clear_sum      = 1'b0;
    store_buffer   = 1'b0;
    next_filter    = 1'b0;
    next_row       = 1'b0;
    busy           = (r_state != IDLE);
    done           = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = ARM;
      end
      ARM: begin
        if (!start) w_next = CFG;
      end
      CFG: begin
        ld_stride      = 1'b1;
        ld_filter_size = 1'b1;
        w_next         = RUN;
      end
      RUN: begin
        put_data   = w_fire;
        put_filter = w_fire;
        if (w_fire && w_elem_last) w_next = STORE;
      end
      STORE: begin
        if (!out_full) begin
          store_buffer = 1'b1;
          clear_sum    = 1'b1;
          next_filter  = end_of_row;
          next_row     = end_of_row & w_filt_last;
          if (end_of_row && w_filt_last && w_row_last) begin
            w_next = DONE;
          end else begin
            w_next = RUN;
          end
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

`ifdef CONV_STALL_CNT_EN
  logic [31:0] r_stall;

  // Count starved RUN cycles and blocked STORE cycles, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (w_in_cfg) begin
      r_stall <= '0;
    end else if ((((r_state == RUN) && !w_fire) || ((r_state == STORE) && out_full))
                 && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module      : tb_conv_scheduler
// Description : Self-checking bench for conv_scheduler: vector table of whole
//               jobs, hand sequences for reset/handshake/back-pressure, and a
//               randomized run against a window/filter/row progress model.
//               Honours CONV_STALL_CNT_EN when defined.
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
module tb_conv_scheduler;

  localparam int BUDGET = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] cfg_fs;
  logic [2:0] cfg_nf;
  logic [7:0] cfg_nr;
  logic       av_data, av_filter, end_of_row, out_full;
  logic       ld_stride, ld_filter_size, put_data, put_filter, clear_sum;
  logic       store_buffer, next_filter, next_row, busy, done;
`ifdef CONV_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  conv_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_filter_size (cfg_fs),
    .cfg_num_filters (cfg_nf),
    .cfg_num_rows    (cfg_nr),
    .av_data         (av_data),
    .av_filter       (av_filter),
    .end_of_row      (end_of_row),
    .out_full        (out_full),
    .ld_stride       (ld_stride),
    .ld_filter_size  (ld_filter_size),
    .put_data        (put_data),
    .put_filter      (put_filter),
    .clear_sum       (clear_sum),
    .store_buffer    (store_buffer),
    .next_filter     (next_filter),
    .next_row        (next_row),
    .busy            (busy),
    .done            (done)
`ifdef CONV_STALL_CNT_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int fs, nf, nr, k;
    int e_puts, e_stores, e_nf, e_nr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 0; av_data = 0; av_filter = 0; end_of_row = 0; out_full = 0;
  endtask

  function automatic logic [9:0] all_outs();
    return {ld_stride, ld_filter_size, put_data, put_filter, clear_sum,
            store_buffer, next_filter, next_row, busy, done};
  endfunction

  // Handshake from IDLE (called at posedge+1); returns at posedge+1 of the first RUN cycle.
  task automatic launch(input int fs, input int nf, input int nr);
    cfg_fs = 4'(fs); cfg_nf = 3'(nf); cfg_nr = 8'(nr);
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    cfg_fs = 4'($urandom); cfg_nf = 3'($urandom); cfg_nr = 8'($urandom);
  endtask

  // Whole job with av=1, no back-pressure, end_of_row on every k-th store of a pass.
  task automatic run_vec(input vec_t v);
    int puts = 0, stores = 0, clears = 0, nfs = 0, nrs = 0, dones = 0;
    int pass_st = 0, cyc = 0, last_store = -100, done_cyc = -1;
    launch(v.fs, v.nf, v.nr);
    while (dones == 0 && cyc < BUDGET) begin
      av_data = 1; av_filter = 1; out_full = 0;
      end_of_row = (pass_st == v.k - 1);
      sample();
      if (put_data)     puts++;
      if (clear_sum)    clears++;
      if (next_filter)  nfs++;
      if (next_row)     nrs++;
      if (store_buffer) begin
        stores++;
        last_store = cyc;
        pass_st = end_of_row ? 0 : pass_st + 1;
      end
      if (done) begin dones++; done_cyc = cyc; end
      tick();
      cyc++;
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      sample();
      if (done) dones++;
      if (i == 0) chk("vec_busy_after_done", busy, 0);
      tick();
    end
    chk("vec_puts", puts, v.e_puts);
    chk("vec_stores", stores, v.e_stores);
    chk("vec_clears", clears, v.e_stores);
    chk("vec_next_filter", nfs, v.e_nf);
    chk("vec_next_row", nrs, v.e_nr);
    chk("vec_done_count", dones, 1);
    chk("vec_done_gap", done_cyc - last_store, 1);
  endtask

  // Randomized job checked cycle by cycle against a window/filter/row progress model.
  task automatic run_model(input int fs, input int nf, input int nr, input bit toggle, input int full_pct);
    int fs_e = (fs == 0) ? 1 : fs;
    int nf_e = (nf == 0) ? 1 : nf;
    int nr_e = (nr == 0) ? 1 : nr;
    int elems = 0, filt = 0, row = 0, cyc = 0;
    longint stall = 0;
    bit collect = 1, pending = 0, dpend = 0, finished = 0;
    bit fire, e_put, e_store, e_nf, e_nr;
    launch(fs, nf, nr);
    while (!finished && cyc < BUDGET) begin
      if (toggle) begin
        av_data = (cyc % 2 == 1); av_filter = av_data; out_full = 0;
      end else begin
        av_data = ($urandom_range(0, 3) != 0);
        av_filter = ($urandom_range(0, 3) != 0);
        out_full = ($urandom_range(0, 99) < full_pct);
      end
      end_of_row = 1'($urandom_range(0, 1));
      fire    = av_data && av_filter;
      e_put   = collect && fire;
      e_store = pending && !out_full;
      e_nf    = e_store && end_of_row;
      e_nr    = e_nf && (filt == nf_e - 1);
      if (collect && !fire)    stall++;
      if (pending && out_full) stall++;
      sample();
      chk("model_outputs",
          {put_data, put_filter, store_buffer, clear_sum, next_filter, next_row, done, busy, ld_stride},
          {e_put, e_put, e_store, e_store, e_nf, e_nr, dpend, 1'b1, 1'b0});
      if (dpend) finished = 1;
      if (e_put) begin
        elems++;
        if (elems == fs_e) begin elems = 0; collect = 0; pending = 1; end
      end
      if (e_store) begin
        pending = 0;
        if (!end_of_row) collect = 1;
        else if (filt != nf_e - 1) begin filt++; collect = 1; end
        else begin
          filt = 0;
          if (row == nr_e - 1) dpend = 1;
          else begin row++; collect = 1; end
        end
      end
      tick();
      cyc++;
    end
    if (!finished) chk("model_timeout", 0, 1);
    idle_inputs();
    sample();
    chk("model_busy_after_done", busy, 0);
`ifdef CONV_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, stall);
`else
    if (stall < 0) chk("stall_model", stall, 0);
`endif
    tick();
  endtask

  initial begin
    int pulses, ld_cyc;
    vecs[0] = '{fs:3, nf:1, nr:1, k:2, e_puts:6,  e_stores:2,  e_nf:1,  e_nr:1};
    vecs[1] = '{fs:2, nf:2, nr:2, k:1, e_puts:8,  e_stores:4,  e_nf:4,  e_nr:2};
    vecs[2] = '{fs:0, nf:0, nr:0, k:1, e_puts:1,  e_stores:1,  e_nf:1,  e_nr:1};
    vecs[3] = '{fs:15, nf:1, nr:1, k:1, e_puts:15, e_stores:1, e_nf:1,  e_nr:1};
    vecs[4] = '{fs:1, nf:7, nr:3, k:2, e_puts:42, e_stores:42, e_nf:21, e_nr:3};

    rst = 1; idle_inputs();
    cfg_fs = 0; cfg_nf = 0; cfg_nr = 0;
    sample();
    chk("reset_outputs", all_outs(), 0);
    start = 1;
    sample();
    chk("reset_ignores_start", all_outs(), 0);
    start = 0;
    @(posedge clk); #1; rst = 0;

    // Start handshake: start high three cycles, ld pulse once in the cycle after release.
    cfg_fs = 1; cfg_nf = 1; cfg_nr = 1;
    pulses = 0; ld_cyc = -1;
    for (int c = 0; c < 7; c++) begin
      start = (c < 3);
      sample();
      if (ld_stride) begin pulses++; ld_cyc = c; end
      if (c == 1) chk("hs_busy_rise", busy, 1);
      chk("hs_ld_pair", ld_stride, ld_filter_size);
      tick();
    end
    chk("hs_ld_pulses", pulses, 1);
    chk("hs_ld_cycle", ld_cyc, 4);
    #1 rst = 1; #2 rst = 0;
    tick();

    // Reset mid-RUN: outputs drop in the same cycle, no done afterwards.
    launch(3, 1, 1);
    av_data = 1; av_filter = 1;
    sample();
    chk("rst_pre_put", put_data, 1);
    #1 rst = 1;
    #1 chk("rst_async_outputs", all_outs(), 0);
    @(posedge clk); #1; rst = 0;
    idle_inputs();
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      sample();
      if (done || busy) pulses++;
      tick();
    end
    chk("rst_stays_idle", pulses, 0);

    // Back-pressure: out_full held five STORE cycles, then store on the sixth.
    launch(1, 1, 1);
    av_data = 1; av_filter = 1; end_of_row = 1; out_full = 1;
    sample();
    chk("bp_first_put", put_data, 1);
    tick();
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      sample();
      if (store_buffer || put_data || put_filter || clear_sum || next_filter || done) pulses++;
      if (!busy) pulses++;
      tick();
    end
    chk("bp_held_activity", pulses, 0);
    out_full = 0;
    sample();
    chk("bp_store_release", {store_buffer, clear_sum, next_filter, next_row, put_data}, 5'b11110);
    tick();
    sample();
    chk("bp_done", done, 1);
    tick();
    idle_inputs();
    sample();
    chk("bp_idle", busy, 0);
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Zero configuration with av toggling behaves as a 1,1,1 job.
    run_model(0, 0, 0, 1'b1, 0);

    for (int i = 0; i < 10; i++) begin
      run_model(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'b0, 30);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
